// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipeline_ctrl_pkg;

  localparam int unsigned REG_ADDR_W          = 5;
  localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_TIMEOUT  = 2'd2
  } ctrl_state_e;

  // Source register conflicts with any in-flight writer; x0 never conflicts.
  function automatic logic src_conflict(
    input logic                  used,
    input logic [REG_ADDR_W-1:0] src,
    input logic [REG_ADDR_W-1:0] ex_rd,
    input logic                  ex_wren,
    input logic [REG_ADDR_W-1:0] mem_rd,
    input logic                  mem_wren,
    input logic [REG_ADDR_W-1:0] wb_rd,
    input logic                  wb_wren
  );
    return used && (src != '0) &&
           ((ex_wren && (ex_rd == src)) ||
            (mem_wren && (mem_rd == src)) ||
            (wb_wren && (wb_rd == src)));
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == '1) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Pipeline-side inputs and stall/flush/status outputs of pipeline_ctrl.
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic [REG_ADDR_W-1:0] i_id_rs1_addr;
  logic [REG_ADDR_W-1:0] i_id_rs2_addr;
  logic                  i_id_rs1_used;
  logic                  i_id_rs2_used;
  logic [REG_ADDR_W-1:0] i_ex_rd_addr;
  logic [REG_ADDR_W-1:0] i_mem_rd_addr;
  logic [REG_ADDR_W-1:0] i_wb_rd_addr;
  logic                  i_ex_rd_wren;
  logic                  i_mem_rd_wren;
  logic                  i_wb_rd_wren;
  logic                  i_mem_pc_sel;
  logic                  i_mem_insn_vld;
  logic                  i_mem_req;
  logic                  i_mem_ready;

  logic                  o_pc_stall;
  logic                  o_if_id_stall;
  logic                  o_id_ex_stall;
  logic                  o_ex_mem_stall;
  logic                  o_mem_wb_stall;
  logic                  o_if_id_flush;
  logic                  o_id_ex_flush;
  logic                  o_ex_mem_flush;
  logic                  o_mem_wb_flush;
  logic [1:0]            o_state;
  logic                  o_mem_timeout;
  logic [31:0]           o_stall_cnt;
  logic [31:0]           o_flush_cnt;

  modport master (
    output i_id_rs1_addr, i_id_rs2_addr, i_id_rs1_used, i_id_rs2_used,
           i_ex_rd_addr, i_mem_rd_addr, i_wb_rd_addr,
           i_ex_rd_wren, i_mem_rd_wren, i_wb_rd_wren,
           i_mem_pc_sel, i_mem_insn_vld, i_mem_req, i_mem_ready,
    input  o_pc_stall, o_if_id_stall, o_id_ex_stall, o_ex_mem_stall, o_mem_wb_stall,
           o_if_id_flush, o_id_ex_flush, o_ex_mem_flush, o_mem_wb_flush,
           o_state, o_mem_timeout, o_stall_cnt, o_flush_cnt
  );

  modport slave (
    input  i_id_rs1_addr, i_id_rs2_addr, i_id_rs1_used, i_id_rs2_used,
           i_ex_rd_addr, i_mem_rd_addr, i_wb_rd_addr,
           i_ex_rd_wren, i_mem_rd_wren, i_wb_rd_wren,
           i_mem_pc_sel, i_mem_insn_vld, i_mem_req, i_mem_ready,
    output o_pc_stall, o_if_id_stall, o_id_ex_stall, o_ex_mem_stall, o_mem_wb_stall,
           o_if_id_flush, o_id_ex_flush, o_ex_mem_flush, o_mem_wb_flush,
           o_state, o_mem_timeout, o_stall_cnt, o_flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// RAW hazard compare of the ID sources against EX, MEM and write-through WB.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic                  ex_rd_wren,
  input  logic                  mem_rd_wren,
  input  logic                  wb_rd_wren,
  output logic                  hazard
);

  always_comb begin
    hazard = src_conflict(rs1_used, rs1_addr, ex_rd_addr, ex_rd_wren,
                          mem_rd_addr, mem_rd_wren, wb_rd_addr, wb_rd_wren) ||
             src_conflict(rs2_used, rs2_addr, ex_rd_addr, ex_rd_wren,
                          mem_rd_addr, mem_rd_wren, wb_rd_addr, wb_rd_wren);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: memory-wait FSM with timeout, redirect
// and RAW-hazard priority mux, saturating performance counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic           i_clk,
  input  logic           i_reset,
  pipeline_ctrl_if.slave bus
);

  localparam logic [8:0] TIMEOUT_LIMIT = 9'(MEM_TIMEOUT);

  ctrl_state_e state, state_next;
  logic [7:0]  wait_cnt, wait_cnt_next;
  logic [8:0]  wait_cnt_inc;
  logic [31:0] stall_cnt, flush_cnt;
  logic        mem_wait, redirect, hazard, timed_out, redirect_taken;
  logic [4:0]  stall;
  logic [3:0]  flush;

  hazard_detect u_hazard (
    .rs1_addr    (bus.i_id_rs1_addr),
    .rs2_addr    (bus.i_id_rs2_addr),
    .rs1_used    (bus.i_id_rs1_used),
    .rs2_used    (bus.i_id_rs2_used),
    .ex_rd_addr  (bus.i_ex_rd_addr),
    .mem_rd_addr (bus.i_mem_rd_addr),
    .wb_rd_addr  (bus.i_wb_rd_addr),
    .ex_rd_wren  (bus.i_ex_rd_wren),
    .mem_rd_wren (bus.i_mem_rd_wren),
    .wb_rd_wren  (bus.i_wb_rd_wren),
    .hazard      (hazard)
  );

  assign mem_wait     = bus.i_mem_req && !bus.i_mem_ready;
  assign redirect     = bus.i_mem_pc_sel && bus.i_mem_insn_vld;
  assign wait_cnt_inc = {1'b0, wait_cnt} + 9'd1;

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      ST_RUN: begin
        wait_cnt_next = '0;
        if (mem_wait) state_next = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        // Ready wins over the timeout on the cycle the limit is reached.
        if (bus.i_mem_ready) begin
          state_next    = ST_RUN;
          wait_cnt_next = '0;
        end else if (mem_wait) begin
          wait_cnt_next = wait_cnt_inc[7:0];
          if (wait_cnt_inc == TIMEOUT_LIMIT) state_next = ST_TIMEOUT;
        end
      end
      ST_TIMEOUT: state_next = ST_TIMEOUT;
      default: begin
        state_next    = ST_RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  // Reset forces the output mux to see RUN even if the register still holds TIMEOUT.
  assign timed_out = (state == ST_TIMEOUT) && !i_reset;

  always_comb begin
    stall          = '0;
    flush          = '0;
    redirect_taken = 1'b0;
    if (timed_out || mem_wait) begin
      stall = '1;
      flush = 4'b0001;
    end else if (redirect) begin
      flush          = 4'b1110;
      redirect_taken = 1'b1;
    end else if (hazard) begin
      stall = 5'b11000;
      flush = 4'b0100;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= ST_RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (|stall)         stall_cnt <= sat_inc(stall_cnt);
      if (redirect_taken) flush_cnt <= sat_inc(flush_cnt);
    end
  end

  assign {bus.o_pc_stall, bus.o_if_id_stall, bus.o_id_ex_stall,
          bus.o_ex_mem_stall, bus.o_mem_wb_stall} = stall;
  assign {bus.o_if_id_flush, bus.o_id_ex_flush,
          bus.o_ex_mem_flush, bus.o_mem_wb_flush} = flush;
  assign bus.o_state       = state;
  assign bus.o_mem_timeout = (state == ST_TIMEOUT);
  assign bus.o_stall_cnt   = stall_cnt;
  assign bus.o_flush_cnt   = flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: vector table, directed multi-cycle sequences and
// randomized traffic against a rule-level reference model.
module tb_pipeline_ctrl;

  localparam int unsigned TMO      = 4;
  localparam logic [8:0]  O_MW     = 9'b11111_0001;
  localparam logic [8:0]  O_RD     = 9'b00000_1110;
  localparam logic [8:0]  O_H      = 9'b11000_0100;
  localparam logic [8:0]  O_NONE   = 9'b00000_0000;
  localparam longint      CNT_MAX  = 64'h0000_0000_FFFF_FFFF;

  typedef struct {
    logic [4:0] rs1, rs2, ex_rd, mem_rd, wb_rd;
    logic       u1, u2, ex_w, mem_w, wb_w;
    logic       pc_sel, vld, req, rdy;
    logic [8:0] exp;
  } vec_t;

  logic clk;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  int     m_state = 0;
  int     m_wait  = 0;
  longint m_stall = 0;
  longint m_flush = 0;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
    input logic [4:0] exr, input logic exw, input logic [4:0] memr, input logic memw,
    input logic [4:0] wbr, input logic wbw, input logic ps, input logic vl,
    input logic rq, input logic rdy, input logic [8:0] e);
    vec_t v;
    v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.ex_rd = exr; v.ex_w = exw; v.mem_rd = memr; v.mem_w = memw;
    v.wb_rd = wbr; v.wb_w = wbw; v.pc_sel = ps; v.vld = vl;
    v.req = rq; v.rdy = rdy; v.exp = e;
    return v;
  endfunction

  function automatic bit raw(input vec_t v);
    logic [4:0] src[2];
    bit         use_src[2];
    logic [4:0] dst[3];
    bit         wr[3];
    src = '{v.rs1, v.rs2};
    use_src = '{v.u1, v.u2};
    dst = '{v.ex_rd, v.mem_rd, v.wb_rd};
    wr  = '{v.ex_w, v.mem_w, v.wb_w};
    for (int s = 0; s < 2; s++)
      for (int d = 0; d < 3; d++)
        if (use_src[s] && src[s] != 5'd0 && wr[d] && dst[d] == src[s]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [8:0] model_out(input vec_t v, input logic r);
    bit to = (m_state == 2) && !r;
    if (to || (v.req && !v.rdy)) return O_MW;
    if (v.pc_sel && v.vld)       return O_RD;
    if (raw(v))                  return O_H;
    return O_NONE;
  endfunction

  task automatic model_edge(input vec_t v, input logic r);
    logic [8:0] o;
    bit mw;
    o  = model_out(v, r);
    mw = v.req && !v.rdy;
    if (r) begin
      m_state = 0; m_wait = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (|o[8:4] && m_stall < CNT_MAX) m_stall++;
      if (o[3] && m_flush < CNT_MAX)    m_flush++;
      case (m_state)
        0: if (mw) begin m_state = 1; m_wait = 0; end
        1: if (v.rdy) begin
             m_state = 0; m_wait = 0;
           end else if (mw) begin
             m_wait++;
             if (m_wait >= int'(TMO)) m_state = 2;
           end
        default: ;
      endcase
    end
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] got_out();
    return {bus.o_pc_stall, bus.o_if_id_stall, bus.o_id_ex_stall, bus.o_ex_mem_stall,
            bus.o_mem_wb_stall, bus.o_if_id_flush, bus.o_id_ex_flush,
            bus.o_ex_mem_flush, bus.o_mem_wb_flush};
  endfunction

  task automatic apply(input vec_t v, input logic r);
    rst = r;
    bus.i_id_rs1_addr = v.rs1;  bus.i_id_rs1_used = v.u1;
    bus.i_id_rs2_addr = v.rs2;  bus.i_id_rs2_used = v.u2;
    bus.i_ex_rd_addr  = v.ex_rd;  bus.i_ex_rd_wren  = v.ex_w;
    bus.i_mem_rd_addr = v.mem_rd; bus.i_mem_rd_wren = v.mem_w;
    bus.i_wb_rd_addr  = v.wb_rd;  bus.i_wb_rd_wren  = v.wb_w;
    bus.i_mem_pc_sel  = v.pc_sel; bus.i_mem_insn_vld = v.vld;
    bus.i_mem_req     = v.req;    bus.i_mem_ready    = v.rdy;
  endtask

  // One cycle: drive at negedge, compare just after, advance model at posedge.
  task automatic step(input vec_t v, input logic r, input string tag);
    apply(v, r);
    #1;
    check({tag, "/out"},       {55'd0, got_out()},       {55'd0, model_out(v, r)});
    check({tag, "/state"},     {62'd0, bus.o_state},     64'(m_state));
    check({tag, "/timeout"},   {63'd0, bus.o_mem_timeout}, {63'd0, m_state == 2});
    check({tag, "/stall_cnt"}, {32'd0, bus.o_stall_cnt}, m_stall);
    check({tag, "/flush_cnt"}, {32'd0, bus.o_flush_cnt}, m_flush);
    @(posedge clk);
    model_edge(v, r);
    @(negedge clk);
  endtask

  vec_t tbl[16];
  vec_t idle, v_mw, v_rdy, v_rd, v_h, v_all, v_all_rdy, rv;
  int   exp_state[5];

  initial begin
    idle      = mk(5'd0,1'b0,5'd0,1'b0, 5'd0,1'b0,5'd0,1'b0,5'd0,1'b0, 1'b0,1'b0,1'b0,1'b0, O_NONE);
    v_mw      = mk(5'd0,1'b0,5'd0,1'b0, 5'd0,1'b0,5'd0,1'b0,5'd0,1'b0, 1'b0,1'b0,1'b1,1'b0, O_MW);
    v_rdy     = mk(5'd0,1'b0,5'd0,1'b0, 5'd0,1'b0,5'd0,1'b0,5'd0,1'b0, 1'b0,1'b0,1'b1,1'b1, O_NONE);
    v_rd      = mk(5'd0,1'b0,5'd0,1'b0, 5'd0,1'b0,5'd0,1'b0,5'd0,1'b0, 1'b1,1'b1,1'b0,1'b0, O_RD);
    v_h       = mk(5'd5,1'b1,5'd0,1'b0, 5'd5,1'b1,5'd0,1'b0,5'd0,1'b0, 1'b0,1'b0,1'b0,1'b0, O_H);
    v_all     = mk(5'd3,1'b1,5'd0,1'b0, 5'd3,1'b1,5'd0,1'b0,5'd0,1'b0, 1'b1,1'b1,1'b1,1'b0, O_MW);
    v_all_rdy = mk(5'd3,1'b1,5'd0,1'b0, 5'd3,1'b1,5'd0,1'b0,5'd0,1'b0, 1'b1,1'b1,1'b1,1'b1, O_RD);

    tbl[0]  = mk(5'd5,1'b1,5'd0,1'b0,  5'd5,1'b1,5'd0,1'b0,5'd0,1'b0,   1'b0,1'b0,1'b0,1'b0, O_H);
    tbl[1]  = mk(5'd5,1'b1,5'd0,1'b0,  5'd0,1'b1,5'd0,1'b0,5'd0,1'b0,   1'b0,1'b0,1'b0,1'b0, O_NONE);
    tbl[2]  = mk(5'd0,1'b1,5'd0,1'b1,  5'd0,1'b1,5'd0,1'b1,5'd0,1'b1,   1'b0,1'b0,1'b0,1'b0, O_NONE);
    tbl[3]  = mk(5'd0,1'b0,5'd7,1'b1,  5'd0,1'b0,5'd7,1'b1,5'd0,1'b0,   1'b0,1'b0,1'b0,1'b0, O_H);
    tbl[4]  = mk(5'd0,1'b0,5'd7,1'b1,  5'd0,1'b0,5'd0,1'b0,5'd7,1'b1,   1'b0,1'b0,1'b0,1'b0, O_H);
    tbl[5]  = mk(5'd9,1'b1,5'd0,1'b0,  5'd9,1'b0,5'd9,1'b0,5'd9,1'b0,   1'b0,1'b0,1'b0,1'b0, O_NONE);
    tbl[6]  = mk(5'd9,1'b0,5'd9,1'b0,  5'd9,1'b1,5'd9,1'b1,5'd9,1'b1,   1'b0,1'b0,1'b0,1'b0, O_NONE);
    tbl[7]  = mk(5'd0,1'b0,5'd0,1'b0,  5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,   1'b1,1'b1,1'b0,1'b0, O_RD);
    tbl[8]  = mk(5'd0,1'b0,5'd0,1'b0,  5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,   1'b1,1'b0,1'b0,1'b0, O_NONE);
    tbl[9]  = mk(5'd5,1'b1,5'd0,1'b0,  5'd5,1'b1,5'd0,1'b0,5'd0,1'b0,   1'b1,1'b1,1'b0,1'b0, O_RD);
    tbl[10] = mk(5'd0,1'b0,5'd0,1'b0,  5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,   1'b0,1'b0,1'b1,1'b0, O_MW);
    tbl[11] = mk(5'd0,1'b0,5'd0,1'b0,  5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,   1'b0,1'b0,1'b1,1'b1, O_NONE);
    tbl[12] = mk(5'd5,1'b1,5'd0,1'b0,  5'd5,1'b1,5'd0,1'b0,5'd0,1'b0,   1'b1,1'b1,1'b1,1'b0, O_MW);
    tbl[13] = mk(5'd0,1'b0,5'd12,1'b1, 5'd0,1'b0,5'd0,1'b0,5'd12,1'b1,  1'b0,1'b0,1'b1,1'b1, O_H);
    tbl[14] = mk(5'd31,1'b1,5'd31,1'b1,5'd30,1'b1,5'd0,1'b0,5'd31,1'b1, 1'b0,1'b0,1'b0,1'b0, O_H);
    tbl[15] = mk(5'd3,1'b1,5'd0,1'b0,  5'd3,1'b0,5'd3,1'b1,5'd0,1'b0,   1'b0,1'b0,1'b0,1'b0, O_H);

    // Bring the DUT out of X before anything is compared.
    apply(idle, 1'b1);
    @(posedge clk);
    model_edge(idle, 1'b1);
    @(negedge clk);
    step(idle, 1'b1, "reset");

    for (int i = 0; i < 16; i++) begin
      apply(tbl[i], 1'b0);
      #1;
      check($sformatf("tbl%0d", i), {55'd0, got_out()}, {55'd0, tbl[i].exp});
      @(posedge clk);
      model_edge(tbl[i], 1'b0);
      @(negedge clk);
      step(idle, 1'b1, "tbl_rst");
    end

    // Redirect flushes for one cycle and counts once.
    step(idle, 1'b1, "rd_rst");
    apply(v_rd, 1'b0); #1;
    check("rd_out", {55'd0, got_out()}, {55'd0, O_RD});
    step(v_rd, 1'b0, "rd");
    check("rd_flush_cnt", {32'd0, bus.o_flush_cnt}, 64'd1);
    step(idle, 1'b0, "rd_after");

    // Three-cycle memory wait.
    step(idle, 1'b1, "mw_rst");
    for (int i = 0; i < 3; i++) begin
      step(v_mw, 1'b0, "mw");
      check("mw_state", {62'd0, bus.o_state}, 64'd1);
    end
    step(v_rdy, 1'b0, "mw_done");
    check("mw_state_end", {62'd0, bus.o_state}, 64'd0);
    check("mw_stall_cnt", {32'd0, bus.o_stall_cnt}, 64'd3);

    // Timeout after the 4th wait cycle, sticky through ready, cleared by reset.
    exp_state = '{1, 1, 1, 1, 2};
    step(idle, 1'b1, "to_rst");
    for (int i = 0; i < 5; i++) begin
      step(v_mw, 1'b0, "to");
      check("to_state", {62'd0, bus.o_state}, 64'(exp_state[i]));
    end
    for (int i = 0; i < 2; i++) begin
      step(v_rdy, 1'b0, "to_hold");
      check("to_hold_flag", {63'd0, bus.o_mem_timeout}, 64'd1);
    end
    step(v_rdy, 1'b1, "to_clear");
    check("to_clear_state", {62'd0, bus.o_state}, 64'd0);
    check("to_clear_flag", {63'd0, bus.o_mem_timeout}, 64'd0);

    // Ready on the cycle the count reaches the limit returns to RUN.
    step(idle, 1'b1, "edge_rst");
    for (int i = 0; i < 4; i++) step(v_mw, 1'b0, "edge");
    step(v_rdy, 1'b0, "edge_rdy");
    check("edge_state", {62'd0, bus.o_state}, 64'd0);

    // Wait masks redirect and hazard; redirect taken once ready arrives.
    step(idle, 1'b1, "all_rst");
    for (int i = 0; i < 2; i++) begin
      apply(v_all, 1'b0); #1;
      check("all_out", {55'd0, got_out()}, {55'd0, O_MW});
      step(v_all, 1'b0, "all");
    end
    check("all_flush_masked", {32'd0, bus.o_flush_cnt}, 64'd0);
    apply(v_all_rdy, 1'b0); #1;
    check("all_rdy_out", {55'd0, got_out()}, {55'd0, O_RD});
    step(v_all_rdy, 1'b0, "all_rdy");
    check("all_flush_taken", {32'd0, bus.o_flush_cnt}, 64'd1);

    // Stall counter saturation.
    step(idle, 1'b1, "sat_rst");
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    m_stall = 64'h0000_0000_FFFF_FFFE;
    for (int i = 0; i < 3; i++) step(v_h, 1'b0, "sat");
    check("sat_stall_cnt", {32'd0, bus.o_stall_cnt}, 64'h0000_0000_FFFF_FFFF);

    // Randomized traffic against the model.
    step(idle, 1'b1, "rnd_rst");
    for (int i = 0; i < 1500; i++) begin
      logic r;
      rv.rs1    = 5'($urandom_range(0, 3));
      rv.rs2    = 5'($urandom_range(0, 3));
      rv.ex_rd  = 5'($urandom_range(0, 3));
      rv.mem_rd = 5'($urandom_range(0, 3));
      rv.wb_rd  = 5'($urandom_range(0, 3));
      rv.u1     = 1'($urandom_range(0, 1));
      rv.u2     = 1'($urandom_range(0, 1));
      rv.ex_w   = 1'($urandom_range(0, 1));
      rv.mem_w  = 1'($urandom_range(0, 1));
      rv.wb_w   = 1'($urandom_range(0, 1));
      rv.pc_sel = ($urandom_range(0, 3) == 0);
      rv.vld    = ($urandom_range(0, 3) != 0);
      rv.req    = ($urandom_range(0, 1) == 0);
      rv.rdy    = ($urandom_range(0, 2) == 0);
      rv.exp    = O_NONE;
      r = ($urandom_range(0, 63) == 0) || (m_state == 2 && $urandom_range(0, 3) == 0);
      step(rv, r, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
